// File: rtl/aes_inv_round_engine.sv
// Iterative AES-128 decryption: one inverse round per SUB/MIX clock pair, plaintext 20 cycles after start.
// Round keys come combinationally from an external store addressed by rk_idx.
module aes_inv_round_engine #(
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     ct_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic [3:0]       rk_idx,
  input  logic [127:0]     rk_in,
  output logic [127:0]     pt_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SUB, MIX} state_e;

  state_e           state_q, state_d;
  logic [127:0]     st_q, st_d;
  logic [127:0]     pt_q, pt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;
  logic [3:0]       rnd_q, rnd_d;
  logic             done_q, done_d;
  logic [127:0]     sub_bytes;
  logic [127:0]     t;
  logic [127:0]     imc;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Packed multiples {14, 13, 11, 9} of one byte.
  function automatic logic [31:0] inv_mults(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x4 ^ a, x8 ^ x2 ^ a, x8 ^ a};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] m2;
    logic [31:0] m3;
    m0 = inv_mults(c[31:24]);
    m1 = inv_mults(c[23:16]);
    m2 = inv_mults(c[15:8]);
    m3 = inv_mults(c[7:0]);
    return {m0[31:24] ^ m1[15:8]  ^ m2[23:16] ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[15:8]  ^ m3[23:16],
            m0[23:16] ^ m1[7:0]   ^ m2[31:24] ^ m3[15:8],
            m0[15:8]  ^ m1[23:16] ^ m2[7:0]   ^ m3[31:24]};
  endfunction

  // Byte (column gi, row gj) is fed from column gi-gj of the state: InvShiftRows folded into the wiring.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      localparam int SRC = 4 * ((gi - gj + 4) % 4) + gj;
      localparam int DST = 4 * gi + gj;
      logic [7:0] sbox_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sbox_q <= 8'h00;
        end else begin
          sbox_q <= inv_sbox(st_q[127-8*SRC -: 8]);
        end
      end
      assign sub_bytes[127-8*DST -: 8] = sbox_q;
    end
    assign imc[127-32*gi -: 32] = inv_mix_col(t[127-32*gi -: 32]);
  end

  assign t = sub_bytes ^ rk_in;

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    pt_d      = pt_q;
    tag_d     = tag_q;
    tag_out_d = tag_out_q;
    rnd_d     = rnd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = ct_in ^ rk_in;
          tag_d   = tag_in;
          rnd_d   = 4'd9;
          state_d = SUB;
        end
      end
      SUB: state_d = MIX;
      MIX: begin
        if (rnd_q != 4'd0) begin
          st_d    = imc;
          rnd_d   = rnd_q - 4'd1;
          state_d = SUB;
        end else begin
          pt_d      = t;
          tag_out_d = tag_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      st_q      <= '0;
      pt_q      <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      rnd_q     <= 4'd9;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      pt_q      <= pt_d;
      tag_q     <= tag_d;
      tag_out_q <= tag_out_d;
      rnd_q     <= rnd_d;
      done_q    <= done_d;
    end
  end

  assign rk_idx  = (state_q == IDLE) ? 4'd10 : rnd_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign pt_out  = pt_q;
  assign tag_out = tag_out_q;

endmodule
